// File: rtl/pipeline_ctrl.sv
// Stall/flush/forward sequencer for the 5-stage pipeline: prioritised hazard strobes,
// EX operand forwarding selects, data-memory timeout flag and saturating perf counters.
module pipeline_ctrl #(
  parameter int REG_NUM_WIDTH = 5,
  parameter int MEM_TIMEOUT   = 15,
  parameter int PERF_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [REG_NUM_WIDTH-1:0] idRs1,
  input  logic [REG_NUM_WIDTH-1:0] idRs2,
  input  logic                     idUsesRs1,
  input  logic                     idUsesRs2,
  input  logic [REG_NUM_WIDTH-1:0] exRs1,
  input  logic [REG_NUM_WIDTH-1:0] exRs2,
  input  logic [REG_NUM_WIDTH-1:0] exRd,
  input  logic                     exMemRead,
  input  logic [REG_NUM_WIDTH-1:0] memRd,
  input  logic [REG_NUM_WIDTH-1:0] wbRd,
  input  logic                     memRegWrite,
  input  logic                     wbRegWrite,
  input  logic                     branchTaken,
  input  logic                     dmemReq,
  input  logic                     dmemReady,
  output logic                     stallPC,
  output logic                     stallIFID,
  output logic                     flushIFID,
  output logic                     bubbleIDEX,
  output logic                     stallIDEX,
  output logic                     stallEXMEM,
  output logic                     bubbleMEMWB,
  output logic [1:0]               forwardA,
  output logic [1:0]               forwardB,
  output logic                     memTimeout,
  output logic [PERF_WIDTH-1:0]    stallCount,
  output logic [PERF_WIDTH-1:0]    flushCount
);

  localparam int WCW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WCW-1:0] WAIT_MAX = WCW'(MEM_TIMEOUT);

  typedef enum logic [1:0] {RUN, LOAD_STALL, MEM_WAIT} state_t;

  state_t         state, stateNext;
  logic [WCW-1:0] waitCnt;
  logic           memWait;
  logic           loadUse;

  function automatic logic [1:0] fwdSel(input logic [REG_NUM_WIDTH-1:0] rs);
    if (rs != '0 && memRegWrite && memRd == rs)
      return 2'b10;
    else if (rs != '0 && wbRegWrite && wbRd == rs)
      return 2'b01;
    else
      return 2'b00;
  endfunction

  assign memWait = dmemReq & ~dmemReady;
  assign loadUse = (state != LOAD_STALL) && exMemRead && (exRd != '0) &&
                   ((idUsesRs1 && idRs1 == exRd) || (idUsesRs2 && idRs2 == exRd));

  // Everything is gated by reset so the datapath sees a quiet pipeline while held.
  always_comb begin
    stallPC     = 1'b0;
    stallIFID   = 1'b0;
    flushIFID   = 1'b0;
    bubbleIDEX  = 1'b0;
    stallIDEX   = 1'b0;
    stallEXMEM  = 1'b0;
    bubbleMEMWB = 1'b0;
    forwardA    = 2'b00;
    forwardB    = 2'b00;
    stateNext   = RUN;
    if (reset) begin
      forwardA = fwdSel(exRs1);
      forwardB = fwdSel(exRs2);
      if (memWait) begin
        // Frozen EX keeps any taken branch alive; it is acted on once memory completes.
        stallPC     = 1'b1;
        stallIFID   = 1'b1;
        stallIDEX   = 1'b1;
        stallEXMEM  = 1'b1;
        bubbleMEMWB = 1'b1;
        stateNext   = MEM_WAIT;
      end else if (branchTaken) begin
        flushIFID  = 1'b1;
        bubbleIDEX = 1'b1;
      end else if (loadUse) begin
        stallPC    = 1'b1;
        stallIFID  = 1'b1;
        bubbleIDEX = 1'b1;
        stateNext  = LOAD_STALL;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= RUN;
      waitCnt    <= '0;
      memTimeout <= 1'b0;
      stallCount <= '0;
      flushCount <= '0;
    end else begin
      state <= stateNext;
      if (memWait) begin
        if (waitCnt != WAIT_MAX)
          waitCnt <= waitCnt + WCW'(1);
        if (waitCnt >= WAIT_MAX - WCW'(1))
          memTimeout <= 1'b1;
      end else begin
        waitCnt <= '0;
      end
      if (stallPC && stallCount != '1)
        stallCount <= stallCount + PERF_WIDTH'(1);
      if (flushIFID && flushCount != '1)
        flushCount <= flushCount + PERF_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed hazard scenarios with literal expectations plus a
// randomized run checked every cycle against a rule-level model of the controller.
module tb_pipeline_ctrl;

  localparam int RNW = 5;
  localparam int MT  = 15;
  localparam int PW  = 6;
  localparam int CMAX = (1 << PW) - 1;

  localparam logic [6:0] S_NONE = 7'b0000000;
  localparam logic [6:0] S_MEM  = 7'b1100111;
  localparam logic [6:0] S_BR   = 7'b0011000;
  localparam logic [6:0] S_LU   = 7'b1101000;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [RNW-1:0] idRs1, idRs2, exRs1, exRs2, exRd, memRd, wbRd;
  logic idUsesRs1, idUsesRs2, exMemRead, memRegWrite, wbRegWrite;
  logic branchTaken, dmemReq, dmemReady;
  logic stallPC, stallIFID, flushIFID, bubbleIDEX, stallIDEX, stallEXMEM, bubbleMEMWB;
  logic [1:0] forwardA, forwardB;
  logic memTimeout;
  logic [PW-1:0] stallCount, flushCount;

  int checks = 0;
  int fails = 0;
  bit chkEn = 1'b0;

  // model state
  int mWait, mStall, mFlush;
  bit mTimeout, mMask;

  pipeline_ctrl #(.REG_NUM_WIDTH(RNW), .MEM_TIMEOUT(MT), .PERF_WIDTH(PW)) dut (
    .clk(clk), .reset(reset),
    .idRs1(idRs1), .idRs2(idRs2), .idUsesRs1(idUsesRs1), .idUsesRs2(idUsesRs2),
    .exRs1(exRs1), .exRs2(exRs2), .exRd(exRd), .exMemRead(exMemRead),
    .memRd(memRd), .wbRd(wbRd), .memRegWrite(memRegWrite), .wbRegWrite(wbRegWrite),
    .branchTaken(branchTaken), .dmemReq(dmemReq), .dmemReady(dmemReady),
    .stallPC(stallPC), .stallIFID(stallIFID), .flushIFID(flushIFID),
    .bubbleIDEX(bubbleIDEX), .stallIDEX(stallIDEX), .stallEXMEM(stallEXMEM),
    .bubbleMEMWB(bubbleMEMWB), .forwardA(forwardA), .forwardB(forwardB),
    .memTimeout(memTimeout), .stallCount(stallCount), .flushCount(flushCount)
  );

  always #5 clk = ~clk;

  wire [6:0] strb = {stallPC, stallIFID, flushIFID, bubbleIDEX, stallIDEX, stallEXMEM, bubbleMEMWB};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected strobes from the priority rules; bit 1 = flush event, bit 0 = load-use fired.
  function automatic logic [8:0] model_strb();
    bit hit, lu;
    hit = (idUsesRs1 && idRs1 == exRd) || (idUsesRs2 && idRs2 == exRd);
    lu  = !mMask && exMemRead && exRd != 0 && hit;
    if (!reset) return 9'b0;
    if (dmemReq && !dmemReady) return {S_MEM, 2'b00};
    if (branchTaken) return {S_BR, 2'b10};
    if (lu) return {S_LU, 2'b01};
    return 9'b0;
  endfunction

  function automatic logic [1:0] model_fwd(input logic [RNW-1:0] rs);
    if (!reset || rs == 0) return 2'b00;
    if (memRegWrite && memRd == rs) return 2'b10;
    if (wbRegWrite && wbRd == rs) return 2'b01;
    return 2'b00;
  endfunction

  always @(posedge clk or negedge reset) begin
    logic [8:0] m;
    if (!reset) begin
      mWait = 0; mStall = 0; mFlush = 0; mTimeout = 0; mMask = 0;
    end else begin
      m = model_strb();
      if (dmemReq && !dmemReady) begin
        mWait = (mWait + 1 > MT) ? MT : mWait + 1;
        if (mWait == MT) mTimeout = 1;
      end else begin
        mWait = 0;
      end
      mMask = m[0];
      if (m[8] && mStall < CMAX) mStall++;
      if (m[1] && mFlush < CMAX) mFlush++;
    end
  end

  always @(negedge clk) begin
    logic [8:0] m;
    if (chkEn) begin
      m = model_strb();
      chk("strobes", 32'(strb), 32'(m[8:2]));
      chk("forwardA", 32'(forwardA), 32'(model_fwd(exRs1)));
      chk("forwardB", 32'(forwardB), 32'(model_fwd(exRs2)));
      chk("memTimeout", 32'(memTimeout), 32'(mTimeout));
      chk("stallCount", 32'(stallCount), 32'(mStall));
      chk("flushCount", 32'(flushCount), 32'(mFlush));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    idRs1 = 0; idRs2 = 0; idUsesRs1 = 0; idUsesRs2 = 0;
    exRs1 = 0; exRs2 = 0; exRd = 0; exMemRead = 0;
    memRd = 0; wbRd = 0; memRegWrite = 0; wbRegWrite = 0;
    branchTaken = 0; dmemReq = 0; dmemReady = 0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    chk("reset_strobes", 32'(strb), 32'(S_NONE));
    chk("reset_counts", 32'({memTimeout, stallCount, flushCount}), 32'(0));
    step();
    step();
    reset = 1'b1;
  endtask

  task automatic rand_cycle();
    idRs1 = RNW'($urandom_range(0, 3)); idRs2 = RNW'($urandom_range(0, 3));
    exRs1 = RNW'($urandom_range(0, 3)); exRs2 = RNW'($urandom_range(0, 3));
    exRd  = RNW'($urandom_range(0, 3)); memRd = RNW'($urandom_range(0, 3));
    wbRd  = RNW'($urandom_range(0, 3));
    idUsesRs1 = 1'($urandom_range(0, 1)); idUsesRs2 = 1'($urandom_range(0, 1));
    exMemRead = ($urandom_range(0, 9) < 5); memRegWrite = 1'($urandom_range(0, 1));
    wbRegWrite = 1'($urandom_range(0, 1)); branchTaken = ($urandom_range(0, 9) < 2);
    dmemReq = ($urandom_range(0, 9) < 3); dmemReady = 1'($urandom_range(0, 1));
  endtask

  initial begin
    idle();
    step();
    #1;
    chkEn = 1'b1;
    chk("reset_strobes", 32'(strb), 32'(S_NONE));
    chk("reset_counts", 32'({memTimeout, stallCount, flushCount}), 32'(0));
    step();
    reset = 1'b1;
    step();

    // load-use on x5: one stall cycle, then masked
    exMemRead = 1; exRd = 5; idRs1 = 5; idUsesRs1 = 1;
    #1 chk("lu_stall", 32'(strb), 32'(S_LU));
    step();
    chk("lu_masked", 32'(strb), 32'(S_NONE));
    chk("lu_count", 32'(stallCount), 32'(1));
    idle(); step();

    // no stall for x0 destination or unused source
    exMemRead = 1; exRd = 0; idRs1 = 0; idUsesRs1 = 1;
    #1 chk("lu_x0", 32'(strb), 32'(S_NONE));
    exRd = 5; idRs1 = 5; idUsesRs1 = 0;
    #1 chk("lu_unused", 32'(strb), 32'(S_NONE));
    idUsesRs2 = 1; idRs2 = 5;
    #1 chk("lu_rs2", 32'(strb), 32'(S_LU));
    idle(); step(); step();

    // branch beats load-use
    exMemRead = 1; exRd = 5; idRs1 = 5; idUsesRs1 = 1; branchTaken = 1;
    #1 chk("br_strobes", 32'(strb), 32'(S_BR));
    chk("br_flush_before", 32'(flushCount), 32'(0));
    step();
    chk("br_flush_after", 32'(flushCount), 32'(1));
    idle(); step();

    // three-cycle memory wait with branch and load-use held behind it
    do_reset();
    dmemReq = 1; dmemReady = 0; branchTaken = 1;
    exMemRead = 1; exRd = 5; idRs1 = 5; idUsesRs1 = 1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("wait_strobes", 32'(strb), 32'(S_MEM));
      step();
    end
    chk("wait_stallcount", 32'(stallCount), 32'(3));
    chk("wait_timeout", 32'(memTimeout), 32'(0));
    dmemReady = 1;
    #1 chk("wait_release", 32'(strb), 32'(S_BR));
    step();
    chk("wait_flushcount", 32'(flushCount), 32'(1));
    idle(); step();

    // memory timeout after 15 consecutive wait edges, sticky until reset
    do_reset();
    dmemReq = 1; dmemReady = 0;
    for (int i = 0; i < MT - 1; i++) step();
    chk("to_before", 32'(memTimeout), 32'(0));
    step();
    chk("to_set", 32'(memTimeout), 32'(1));
    step(); step(); step();
    dmemReady = 1; step();
    chk("to_sticky", 32'(memTimeout), 32'(1));
    idle(); step();
    chk("to_sticky_idle", 32'(memTimeout), 32'(1));
    do_reset();
    chk("to_cleared", 32'(memTimeout), 32'(0));

    // forwarding priority and x0 exclusion
    exRs1 = 7; exRs2 = 7; memRd = 7; wbRd = 7; memRegWrite = 1; wbRegWrite = 1;
    #1 chk("fwd_mem", 32'({forwardA, forwardB}), 32'(4'b1010));
    memRegWrite = 0;
    #1 chk("fwd_wb", 32'({forwardA, forwardB}), 32'(4'b0101));
    exRs1 = 0;
    #1 chk("fwd_x0", 32'({forwardA, forwardB}), 32'(4'b0001));
    idle(); step();

    // reset asserted mid-wait forces every output low immediately
    dmemReq = 1; exRs1 = 7; memRd = 7; memRegWrite = 1;
    step(); step();
    reset = 1'b0;
    #1 chk("rst_mid_strobes", 32'(strb), 32'(S_NONE));
    chk("rst_mid_fwd", 32'(forwardA), 32'(0));
    step();
    reset = 1'b1;
    #1 chk("rst_rel_strobes", 32'(strb), 32'(S_MEM));
    chk("rst_rel_fwd", 32'(forwardA), 32'(2'b10));
    idle(); step();

    // randomized traffic with occasional asynchronous reset
    for (int i = 0; i < 1500; i++) begin
      rand_cycle();
      if ($urandom_range(0, 299) == 0) begin
        #2 reset = 1'b0;
        step();
        reset = 1'b1;
      end else begin
        step();
      end
    end
    do_reset();
    for (int i = 0; i < 600; i++) begin
      rand_cycle();
      step();
    end
    chk("sat_stall", 32'(stallCount), 32'(CMAX));
    chk("sat_flush", 32'(flushCount), 32'(CMAX));
    idle();
    step();
    chkEn = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
